// File: rtl/bus_uart_tx_pkg.sv
// bus_uart_tx_pkg
//   Shared types and constants for the bus-attached UART transmitter:
//   TX state encoding, register offsets (addr[3:2]) and STATUS bit positions.
package bus_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  localparam int STATUS_FULL  = 0;
  localparam int STATUS_EMPTY = 1;
  localparam int STATUS_BUSY  = 2;
  localparam int STATUS_OVF   = 3;

endpackage

// File: rtl/bus_uart_tx_if.sv
// bus_uart_tx_if
//   Ibex-style data bus (req/gnt/rvalid) between a bus master and this slave.
//   Request side : req, we, be[3:0], addr[31:0], wdata[31:0]
//   Response side: gnt, rvalid, rdata[31:0], err
interface bus_uart_tx_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/bus_uart_tx_fifo_sync.sv
// fifo_sync
//   Single-clock FIFO with wrap-bit pointers.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, wdata   : write request and data; accepted when not full, or when
//                   full but popping in the same cycle
//   pop, rdata    : read request; rdata shows the head entry (first-word fall-through)
//   full, empty   : occupancy flags
//   count         : number of stored entries
module fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);
  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  // Extra MSB on each pointer tells full (MSBs differ) from empty (equal).
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx
//   Memory-mapped 8N1 UART transmitter on the Ibex data bus.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of the req/gnt/rvalid bus (gnt = req, response 1 cycle later)
//   tx_o   : serial output, idle high, driven from a flop
//   busy_o : FIFO non-empty or a frame in flight
//   Registers (addr[3:2]): 0 TXDATA, 1 STATUS {OVF,busy,empty,full}, 2 DIV, 3 error.
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bus_uart_tx_if.slave  bus,
  output logic          tx_o,
  output logic          busy_o
);
  logic [1:0]  reg_sel;
  logic        wr_txdata, wr_div, rd_status, err_d, ovf_set;
  logic [31:0] rdata_d;
  logic [3:0]  status;
  logic        rvalid_q, err_q, ovf_q;
  logic [31:0] rdata_q;
  logic [15:0] div_q;

  logic                        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]                  fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  tx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d, reload_q, reload_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.be[3:2], bus.wdata[31:16]};

  assign reg_sel = bus.addr[3:2];
  assign bus.gnt = bus.req;
  assign busy_o  = (fifo_count != '0) || (state_q != IDLE);
  assign ovf_set = wr_txdata && fifo_full && !fifo_pop;

  always_comb begin
    status               = '0;
    status[STATUS_FULL]  = fifo_full;
    status[STATUS_EMPTY] = fifo_empty;
    status[STATUS_BUSY]  = busy_o;
    status[STATUS_OVF]   = ovf_q | ovf_set;
  end

  always_comb begin
    wr_txdata = 1'b0;
    wr_div    = 1'b0;
    rd_status = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    if (bus.req) begin
      case (reg_sel)
        UART_TXDATA: wr_txdata = bus.we && bus.be[0];
        UART_STATUS: begin
          if (!bus.we) begin
            rd_status = 1'b1;
            rdata_d   = {28'd0, status};
          end
        end
        UART_DIV: begin
          if (bus.we) wr_div  = 1'b1;
          else        rdata_d = {16'd0, div_q};
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Response slice: every granted request answers exactly one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.req;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

  // A new overflow in the same cycle as a STATUS read keeps OVF set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= DIV_RESET;
      ovf_q <= 1'b0;
    end else begin
      if (wr_div && bus.be[0]) div_q[7:0]  <= bus.wdata[7:0];
      if (wr_div && bus.be[1]) div_q[15:8] <= bus.wdata[15:8];
      if (ovf_set)             ovf_q <= 1'b1;
      else if (rd_status)      ovf_q <= 1'b0;
    end
  end

  fifo_sync #(.Width(8), .Depth(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (wr_txdata),
    .wdata (bus.wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // tx_d is the line level for the state being entered, so the tx flop
  // changes on the same edge as the state register.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    reload_d  = reload_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          reload_d = div_q;
          timer_d  = div_q;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          timer_d   = reload_q;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = reload_q;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            reload_d = div_q;
            timer_d  = div_q;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      reload_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      reload_q  <= reload_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx
//   Self-checking bench for bus_uart_tx. Bytes expected on the serial line are
//   queued with the divisor they must use; a line monitor pops and compares
//   every frame sample by sample.
module tb_bus_uart_tx;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  logic tx_o, busy_o;

  always #5 clk_i = ~clk_i;

  bus_uart_tx_if bus ();

  bus_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd103)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus),
    .tx_o  (tx_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   frames_done = 0;
  int   last_gap = 0;

  // Line monitor: samples on falling clock edges, decodes one frame per start bit.
  initial begin : monitor
    int         idle_cnt;
    exp_t       e;
    logic [9:0] exp_bits, obs_bits;
    int         mism;
    bit         aborted;
    idle_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        idle_cnt = 0;
        continue;
      end
      if (tx_o !== 1'b0) begin
        idle_cnt++;
        continue;
      end
      last_gap = idle_cnt;
      idle_cnt = 0;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_frame: start bit seen, expected no frame");
        for (int k = 0; k < 5000 && tx_o !== 1'b1; k++) @(negedge clk_i);
        continue;
      end
      e        = sb.pop_front();
      exp_bits = {1'b1, e.data, 1'b0};
      obs_bits = '0;
      mism     = 0;
      aborted  = 1'b0;
      for (int b = 0; b < 10 && !aborted; b++) begin
        for (int s = 0; s <= e.div && !aborted; s++) begin
          if (!(b == 0 && s == 0)) @(negedge clk_i);
          if (!rst_ni) aborted = 1'b1;
          else begin
            if (s == 0) obs_bits[b] = tx_o;
            if (tx_o !== exp_bits[b]) mism++;
          end
        end
      end
      if (aborted) continue;
      total++;
      if (mism != 0 || obs_bits !== exp_bits) begin
        bad++;
        $display("[TB] FAIL frame: got bits=%b with %0d bad samples, expected bits=%b (div=%0d)",
                 obs_bits, mism, exp_bits, e.div);
      end
      frames_done++;
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One bus transfer; entered and left at posedge+1.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic g, output logic rv_pre,
                          output logic rv, output logic [31:0] rd, output logic e);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.be    = b;
    #1;
    g      = bus.gnt;
    rv_pre = bus.rvalid;
    @(posedge clk_i);
    #1;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;
    rv = bus.rvalid;
    rd = bus.rdata;
    e  = bus.err;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic g, rvp, rv, e;
    logic [31:0] rd;
    bus_xfer(1'b1, a, d, b, g, rvp, rv, rd, e);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (frames_done < target && cyc < budget) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.we = 1'b0; bus.be = '0; bus.addr = '0; bus.wdata = '0;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (tx_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b want 1", tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 0", bus.rvalid); end
    total++; if (bus.rdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.rdata); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.err); end
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_status_read();
    logic g, rvp, rv, e;
    logic [31:0] rd;
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (g !== 1'b1) begin bad++; $display("[TB] FAIL status_gnt: got %b want 1", g); end
    total++; if (rvp !== 1'b0) begin bad++; $display("[TB] FAIL status_rvalid_early: got %b want 0", rvp); end
    total++; if (rv !== 1'b1) begin bad++; $display("[TB] FAIL status_rvalid: got %b want 1", rv); end
    total++; if (rd !== 32'h2) begin bad++; $display("[TB] FAIL status_rdata: got %h want 2", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL status_err: got %b want 0", e); end
    @(posedge clk_i);
    #1;
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rvalid_one_cycle: got %b want 0", bus.rvalid); end
    bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rd !== 32'd103) begin bad++; $display("[TB] FAIL div_reset: got %0d want 103", rd); end
  endtask

  task automatic test_basic_frame();
    int n;
    write_reg(32'h8, 32'd3, 4'b0011);
    n = frames_done;
    sb.push_back('{8'h55, 3});
    write_reg(32'h0, 32'h55, 4'b0001);
    wait_frames(n + 1, 200);
    total++; if (frames_done !== n + 1) begin bad++; $display("[TB] FAIL basic_frames: got %0d want %0d", frames_done, n + 1); end
    total++; if (sb.size() !== 0) begin bad++; $display("[TB] FAIL basic_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_overflow();
    int n;
    logic g, rvp, rv, e;
    logic [31:0] rd;
    write_reg(32'h8, 32'd0, 4'b0011);
    repeat (2) @(posedge clk_i);
    #1;
    n = frames_done;
    for (int i = 0; i < 10; i++) begin
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0; bus.be = 4'b0001;
      bus.wdata = 32'(8'h10 + i);
      if (i < 9) sb.push_back('{8'(8'h10 + i), 0});
      @(posedge clk_i);
      #1;
    end
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rd[3:0] !== 4'hD) begin bad++; $display("[TB] FAIL ovf_status: got %h want d", rd[3:0]); end
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rd[3] !== 1'b0) begin bad++; $display("[TB] FAIL ovf_cleared: got %b want 0", rd[3]); end
    wait_frames(n + 9, 500);
    total++; if (frames_done !== n + 9) begin bad++; $display("[TB] FAIL ovf_frames: got %0d want %0d", frames_done, n + 9); end
    @(posedge clk_i);
    #1;
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rd !== 32'h2) begin bad++; $display("[TB] FAIL ovf_drained: got %h want 2", rd); end
  endtask

  task automatic test_back_to_back();
    int  n, cyc;
    bit  early;
    write_reg(32'h8, 32'd3, 4'b0011);
    n = frames_done;
    sb.push_back('{8'hA5, 3});
    sb.push_back('{8'h3C, 3});
    write_reg(32'h0, 32'hA5, 4'b0001);
    write_reg(32'h0, 32'h3C, 4'b0001);
    early = 1'b0;
    cyc   = 0;
    while (cyc < 300) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (frames_done >= n + 2) break;
      if (busy_o !== 1'b1) early = 1'b1;
    end
    total++; if (frames_done !== n + 2) begin bad++; $display("[TB] FAIL b2b_frames: got %0d want %0d", frames_done, n + 2); end
    total++; if (early !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy_early: got drop=%b want 0", early); end
    total++; if (last_gap !== 0) begin bad++; $display("[TB] FAIL b2b_gap: got %0d want 0", last_gap); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_div_change();
    int n;
    logic g, rvp, rv, e;
    logic [31:0] rd;
    n = frames_done;
    sb.push_back('{8'hC3, 3});
    write_reg(32'h0, 32'hC3, 4'b0001);
    repeat (6) @(posedge clk_i);
    #1;
    write_reg(32'h8, 32'd7, 4'b0011);
    sb.push_back('{8'h81, 7});
    write_reg(32'h0, 32'h81, 4'b0001);
    wait_frames(n + 2, 400);
    total++; if (frames_done !== n + 2) begin bad++; $display("[TB] FAIL divchg_frames: got %0d want %0d", frames_done, n + 2); end
    total++; if (last_gap !== 0) begin bad++; $display("[TB] FAIL divchg_gap: got %0d want 0", last_gap); end
    bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rd !== 32'd7) begin bad++; $display("[TB] FAIL divchg_readback: got %0d want 7", rd); end
  endtask

  task automatic test_error_and_reset();
    logic g, rvp, rv, e;
    logic [31:0] rd;
    int n;
    bus_xfer(1'b0, 32'hC, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rv !== 1'b1 || e !== 1'b1) begin bad++; $display("[TB] FAIL err_read: got rvalid=%b err=%b want 1 1", rv, e); end
    total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL err_rdata: got %h want 0", rd); end
    bus_xfer(1'b1, 32'hC, 32'h1234, 4'hF, g, rvp, rv, rd, e);
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL err_write: got %b want 1", e); end
    write_reg(32'h8, 32'd3, 4'b0011);
    sb.push_back('{8'hF0, 3});
    write_reg(32'h0, 32'hF0, 4'b0001);
    write_reg(32'h0, 32'h11, 4'b0001);
    repeat (8) @(posedge clk_i);
    #1;
    total++; if (tx_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_data_tx: got %b want 0", tx_o); end
    rst_ni = 1'b0;
    #1;
    total++; if (tx_o !== 1'b1) begin bad++; $display("[TB] FAIL async_reset_tx: got %b want 1", tx_o); end
    sb.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    n = frames_done;
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rd !== 32'h2) begin bad++; $display("[TB] FAIL post_reset_status: got %h want 2", rd); end
    bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, g, rvp, rv, rd, e);
    total++; if (rd !== 32'd103) begin bad++; $display("[TB] FAIL post_reset_div: got %0d want 103", rd); end
    repeat (20) @(posedge clk_i);
    #1;
    total++; if (tx_o !== 1'b1 || frames_done !== n) begin bad++; $display("[TB] FAIL post_reset_idle: got tx=%b frames=%0d want 1 %0d", tx_o, frames_done, n); end
  endtask

  initial begin
    test_reset();
    test_status_read();
    test_basic_frame();
    test_overflow();
    test_back_to_back();
    test_div_change();
    test_error_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
